branch_predictor: RTL

- Bimodal branch predictor directly upstream of the fetch stage; drives the fetch stage's `prediction` input.
- Looks up a table of 2-bit saturating counters, indexed by the current fetch PC.
- Trains the addressed counter when a conditional branch resolves in EX.
- Keeps saturating branch and mispredict statistics counters for performance debug.

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/branch_predictor_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 69 ++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared opcode constants and branch-history counter encoding for the front end.
// Types and constants only; no timing or flow-control behaviour.
package branch_predictor_pkg;

  localparam logic [6:0] B_type = 7'b1100011;
  localparam logic [6:0] J_type = 7'b1101111;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
  localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
  localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
  localparam bht_ctr_t BHT_STRONG_T  = 2'b11;
  localparam bht_ctr_t BHT_RESET_VAL = BHT_WEAK_T;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating taken/not-taken counter.
// Purely combinational, zero latency; no flow control.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bht_ctr_t cur,
  input  logic     taken,
  output bht_ctr_t next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != BHT_STRONG_T) next = cur + 2'b01;
    end else begin
      if (cur != BHT_STRONG_NT) next = cur - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal predictor: untagged table of 2-bit counters read by fetch PC, trained from EX.
// Combinational prediction (zero latency); stall suppresses training and statistics updates.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           fetch_pc,
  input  logic [31:0]           fetch_instr,
  output logic                  prediction,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic [31:0]           ex_pc,
  input  logic                  ex_taken,
  input  logic                  ex_predicted,
  input  logic                  stall,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int INDEX_BITS = $clog2(BHT_ENTRIES);

  bht_ctr_t              bht [BHT_ENTRIES];
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  train;
  bht_ctr_t              wr_next;

  assign rd_idx = fetch_pc[INDEX_BITS+1:2];
  assign wr_idx = ex_pc[INDEX_BITS+1:2];
  assign train  = ex_valid & ex_is_branch & ~stall;

  // No write-to-read bypass: a same-index update shows up one cycle later.
  assign prediction = bht[rd_idx][1] & (fetch_instr[6:0] == B_type);

  sat_counter2 u_sat (
    .cur   (bht[wr_idx]),
    .taken (ex_taken),
    .next  (wr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_RESET_VAL;
    end else if (train) begin
      bht[wr_idx] <= wr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (train) begin
      if (branch_count != {STAT_WIDTH{1'b1}})
        branch_count <= branch_count + 1'b1;
      if ((ex_taken != ex_predicted) && (mispredict_count != {STAT_WIDTH{1'b1}}))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                         ex_pc[31:INDEX_BITS+2], ex_pc[1:0], fetch_instr[31:7]};

endmodule
